// File: rtl/Isa.sv
// Processor ISA constants shared by the core, its memory and the boot loader.
package Isa;

  localparam int INSTRUCTION_SIZE     = 16;
  localparam int MEMORY_ADDRESS_WIDTH = 8;
  localparam int MEMORY_DEPTH         = 256;

endpackage : Isa

// File: rtl/loader_pkg.sv
// Types and constants for the boot-time program loader.
package loader_pkg;

  // Loader FSM states; the stream is LEN_HI, LEN_LO, N x (DATA_HI, DATA_LO), checksum.
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LEN_HI  = 4'd1,
    LEN_LO  = 4'd2,
    DATA_HI = 4'd3,
    DATA_LO = 4'd4,
    WRITE   = 4'd5,
    CHECK   = 4'd6,
    DONE    = 4'd7,
    ERROR   = 4'd8
  } loader_state_t;

  // Each RAM word arrives as two stream bytes, high byte first.
  localparam int LOADER_BYTES_PER_WORD = 2;

endpackage : loader_pkg

// File: rtl/program_loader.sv
// Boot-time program loader: receives a length-prefixed, XOR-checksummed byte
// stream, writes the assembled words to RAM from address 0 and releases the
// processor from reset only after a good checksum.
module program_loader
  import loader_pkg::*;
#(
  parameter int WORD_WIDTH = Isa::INSTRUCTION_SIZE,
  parameter int ADDR_WIDTH = Isa::MEMORY_ADDRESS_WIDTH,
  parameter int DEPTH      = Isa::MEMORY_DEPTH
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [7:0]            i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_ram_write_enable,
  output logic [ADDR_WIDTH-1:0] o_ram_address,
  output logic [WORD_WIDTH-1:0] o_ram_write_data,
  output logic                  o_cpu_reset,
  output logic                  o_done,
  output logic                  o_error
);

  // Largest legal word count, widened so a 16-bit length can exceed it.
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  loader_state_t           state_q, state_d;
  logic [15:0]             len_q,   len_d;
  logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic [7:0]              csum_q,  csum_d;
  logic [WORD_WIDTH-1:0]   word_q,  word_d;

  logic                    byte_accept;
  logic                    restart;
  logic [15:0]             len_full;

  // A byte moves only on valid && ready; ready itself is decoded from state.
  assign byte_accept = i_valid && o_ready;
  assign restart     = i_start && (state_q inside {IDLE, DONE, ERROR});
  assign len_full    = {len_q[15:8], i_data};

  // State and datapath registers; reset parks the loader idle with the CPU held.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      count_q <= '0;
      csum_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      csum_q  <= csum_d;
      word_q  <= word_d;
    end
  end

  // Next-state and datapath update logic driven by accepted stream bytes.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    count_d = count_q;
    csum_d  = csum_q;
    word_d  = word_q;

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (restart) state_d = LEN_HI;
      end
      LEN_HI: begin
        if (byte_accept) begin
          len_d[15:8] = i_data;
          state_d     = LEN_LO;
        end
      end
      LEN_LO: begin
        if (byte_accept) begin
          len_d[7:0] = i_data;
          // Oversized loads are refused before any RAM write, so addr never wraps.
          if ({1'b0, len_full} > DEPTH_W) state_d = ERROR;
          else if (len_full == 16'd0)     state_d = CHECK;
          else                            state_d = DATA_HI;
        end
      end
      DATA_HI: begin
        if (byte_accept) begin
          word_d[WORD_WIDTH-1 -: 8] = i_data;
          csum_d                    = csum_q ^ i_data;
          state_d                   = DATA_LO;
        end
      end
      DATA_LO: begin
        if (byte_accept) begin
          word_d[7:0] = i_data;
          csum_d      = csum_q ^ i_data;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        addr_d  = addr_q + ADDR_WIDTH'(1);
        count_d = count_q + (ADDR_WIDTH + 1)'(1);
        if (16'(count_q) + 16'd1 == len_q) state_d = CHECK;
        else                               state_d = DATA_HI;
      end
      CHECK: begin
        if (byte_accept) begin
          state_d = (i_data == csum_q) ? DONE : ERROR;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every new load starts from address 0 with an empty checksum.
    if (restart) begin
      addr_d  = '0;
      count_d = '0;
      csum_d  = '0;
    end
  end

  // Outputs decoded from the registered state only; RAM bus reads 0 when not writing.
  always_comb begin
    o_ready            = 1'b0;
    o_ram_write_enable = 1'b0;
    o_ram_address      = '0;
    o_ram_write_data   = '0;
    o_cpu_reset        = 1'b0;
    o_done             = 1'b0;
    o_error            = 1'b0;
    unique case (state_q)
      LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK: o_ready = 1'b1;
      WRITE: begin
        o_ram_write_enable = 1'b1;
        o_ram_address      = addr_q;
        o_ram_write_data   = word_q;
      end
      DONE: begin
        o_done      = 1'b1;
        o_cpu_reset = 1'b1;
      end
      ERROR:   o_error = 1'b1;
      default: o_ready = 1'b0;
    endcase
  end

endmodule : program_loader

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed and random byte streams
// compared against a stream-level reference model of the expected RAM writes.
module tb_program_loader;
  import loader_pkg::*;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_data  = 8'h00;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        o_ram_write_enable;
  logic [7:0]  o_ram_address;
  logic [15:0] o_ram_write_data;
  logic        o_cpu_reset;
  logic        o_done;
  logic        o_error;

  program_loader dut (
    .i_clock            (i_clock),
    .i_reset            (i_reset),
    .i_start            (i_start),
    .i_data             (i_data),
    .i_valid            (i_valid),
    .o_ready            (o_ready),
    .o_ram_write_enable (o_ram_write_enable),
    .o_ram_address      (o_ram_address),
    .o_ram_write_data   (o_ram_write_data),
    .o_cpu_reset        (o_cpu_reset),
    .o_done             (o_done),
    .o_error            (o_error)
  );

  always #5 i_clock = ~i_clock;

  int vectors     = 0;
  int miscompares = 0;

  // Stream under test and the model's expectations for it.
  logic [7:0]  stream [$];
  int          exp_addr [$];
  logic [15:0] exp_data [$];
  bit          exp_done;
  bit          exp_error;

  // Observed RAM writes and the RAM contents they produce.
  int          got_addr [$];
  logic [15:0] got_data [$];
  logic [15:0] mem [0:255];

  always @(negedge i_clock) begin
    if (o_ram_write_enable === 1'b1) begin
      got_addr.push_back(int'(o_ram_address));
      got_data.push_back(o_ram_write_data);
      mem[o_ram_address] <= o_ram_write_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Present one byte, optionally after random idle cycles, and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget;
    if (gaps) begin
      i_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge i_clock);
    end
    i_valid = 1'b1;
    i_data  = b;
    budget  = 0;
    while (o_ready !== 1'b1 && budget < 20) begin
      @(negedge i_clock);
      budget++;
    end
    if (budget >= 20) chk("ready_timeout", 32'(o_ready), 32'd1);
    @(negedge i_clock);
    i_valid = 1'b0;
  endtask

  // Reference model: what a load of `stream` must write and how it must end.
  task automatic build_model();
    int n;
    logic [7:0] x;
    n = int'({stream[0], stream[1]});
    exp_addr.delete();
    exp_data.delete();
    if (n > 256) begin
      exp_done  = 1'b0;
      exp_error = 1'b1;
    end else begin
      x = 8'h00;
      for (int k = 0; k < n; k++) begin
        exp_addr.push_back(k);
        exp_data.push_back({stream[2 + 2*k], stream[3 + 2*k]});
        x = x ^ stream[2 + 2*k] ^ stream[3 + 2*k];
      end
      exp_done  = (stream[2 + 2*n] == x);
      exp_error = !exp_done;
    end
  endtask

  task automatic rand_stream(input int n, input bit bad);
    logic [7:0] x;
    logic [7:0] b;
    stream.delete();
    stream.push_back(8'(n >> 8));
    stream.push_back(8'(n));
    x = 8'h00;
    for (int k = 0; k < 2*n; k++) begin
      b = 8'($urandom_range(0, 255));
      stream.push_back(b);
      x = x ^ b;
    end
    stream.push_back(bad ? (x ^ 8'h01) : x);
  endtask

  task automatic start_pulse();
    i_start = 1'b1;
    @(negedge i_clock);
    i_start = 1'b0;
    chk("cpu_reset_after_start", 32'(o_cpu_reset), 32'd0);
    chk("state_after_start", 32'(dut.state_q), 32'(LEN_HI));
  endtask

  // Run one full load of `stream` and compare writes and completion flags.
  task automatic run_load(input string name, input bit gaps);
    build_model();
    got_addr.delete();
    got_data.delete();
    start_pulse();
    foreach (stream[i]) send_byte(stream[i], gaps);
    chk({name, "_done"},      32'(o_done),      32'(exp_done));
    chk({name, "_error"},     32'(o_error),     32'(exp_error));
    chk({name, "_cpu_reset"}, 32'(o_cpu_reset), 32'(exp_done));
    chk({name, "_nwrites"},   32'(got_addr.size()), 32'(exp_addr.size()));
    for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
      chk({name, "_waddr"}, 32'(got_addr[k]), 32'(exp_addr[k]));
      chk({name, "_wdata"}, 32'(got_data[k]), 32'(exp_data[k]));
    end
    $display("load %s: N=%0d writes=%0d done=%0b error=%0b cpu_reset=%0b",
             name, exp_addr.size(), got_addr.size(), o_done, o_error, o_cpu_reset);
  endtask

  task automatic nominal_stream(input logic [7:0] ck);
    stream.delete();
    stream.push_back(8'h00); stream.push_back(8'h03);
    stream.push_back(8'h23); stream.push_back(8'h01);
    stream.push_back(8'h45); stream.push_back(8'h00);
    stream.push_back(8'h00); stream.push_back(8'h00);
    stream.push_back(ck);
  endtask

  initial begin
    // Reset state, asserted from time 0.
    #1;
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_we",    32'(o_ram_write_enable), 32'd0);
    chk("rst_addr",  32'(o_ram_address), 32'd0);
    chk("rst_wdata", 32'(o_ram_write_data), 32'd0);
    chk("rst_cpu",   32'(o_cpu_reset), 32'd0);
    chk("rst_done",  32'(o_done), 32'd0);
    chk("rst_error", 32'(o_error), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    repeat (3) @(negedge i_clock);
    i_reset = 1'b1;
    @(negedge i_clock);
    chk("idle_ready", 32'(o_ready), 32'd0);

    // Nominal three-word load with known contents.
    nominal_stream(8'h67);
    run_load("nominal", 1'b0);
    chk("nom_mem0", 32'(mem[0]), 32'h2301);
    chk("nom_mem1", 32'(mem[1]), 32'h4500);
    chk("nom_mem2", 32'(mem[2]), 32'h0000);
    chk("nom_done", 32'(o_done), 32'd1);

    // Bad checksum, then recovery by restarting from ERROR.
    nominal_stream(8'h66);
    run_load("badsum", 1'b0);
    chk("badsum_error", 32'(o_error), 32'd1);
    chk("badsum_cpu", 32'(o_cpu_reset), 32'd0);
    nominal_stream(8'h67);
    run_load("recover", 1'b0);
    chk("recover_done", 32'(o_done), 32'd1);

    // Length overflow: 257 words refused with no write.
    stream.delete();
    stream.push_back(8'h01); stream.push_back(8'h01);
    run_load("overflow", 1'b0);
    chk("overflow_error", 32'(o_error), 32'd1);
    chk("overflow_nowrite", 32'(got_addr.size()), 32'd0);

    // Full-depth load of 256 words; last write lands at 255.
    rand_stream(256, 1'b0);
    run_load("full256", 1'b0);
    if (got_addr.size() == 256) chk("full256_last_addr", 32'(got_addr[255]), 32'd255);
    else chk("full256_count", 32'(got_addr.size()), 32'd256);

    // Empty program: good and bad checksum.
    stream.delete();
    stream.push_back(8'h00); stream.push_back(8'h00); stream.push_back(8'h00);
    run_load("empty_ok", 1'b0);
    chk("empty_ok_done", 32'(o_done), 32'd1);
    stream[2] = 8'h01;
    run_load("empty_bad", 1'b0);
    chk("empty_bad_error", 32'(o_error), 32'd1);

    // 256 random words with random valid gaps.
    rand_stream(256, 1'b0);
    run_load("gaps256", 1'b1);
    @(negedge i_clock);
    for (int k = 0; k < 256; k++) chk("gaps256_mem", 32'(mem[k]), 32'(exp_data[k]));

    // Asynchronous reset during DATA_LO of word 5.
    rand_stream(10, 1'b0);
    build_model();
    start_pulse();
    for (int i = 0; i < 13; i++) send_byte(stream[i], 1'b0);
    chk("midrst_state_before", 32'(dut.state_q), 32'(DATA_LO));
    i_valid = 1'b1;
    i_data  = stream[13];
    #1;
    i_reset = 1'b0;
    #1;
    chk("midrst_ready", 32'(o_ready), 32'd0);
    chk("midrst_we",    32'(o_ram_write_enable), 32'd0);
    chk("midrst_cpu",   32'(o_cpu_reset), 32'd0);
    chk("midrst_done",  32'(o_done), 32'd0);
    chk("midrst_error", 32'(o_error), 32'd0);
    chk("midrst_state", 32'(dut.state_q), 32'(IDLE));
    $display("reset mid-load: state=%0d ready=%0b", dut.state_q, o_ready);
    i_valid = 1'b0;
    @(negedge i_clock);
    i_reset = 1'b1;
    @(negedge i_clock);
    chk("midrst_mem4_kept", 32'(mem[4]), 32'(exp_data[4]));
    rand_stream(2, 1'b0);
    run_load("after_reset", 1'b1);
    chk("after_reset_mem0", 32'(mem[0]), 32'({stream[2], stream[3]}));
    chk("after_reset_mem1", 32'(mem[1]), 32'({stream[4], stream[5]}));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_program_loader

// File: doc/program_loader.md
# program_loader

Boot-time program loader that sits directly upstream of the processor and its single-port RAM. It receives a byte stream over a valid/ready handshake containing a word count, instruction/data words and an XOR checksum. It writes each assembled word into RAM at consecutive addresses from 0. After a good checksum it releases the processor from reset; on any error it holds the processor in reset.

## Interface
Parameters:
- `WORD_WIDTH`, default `Isa::INSTRUCTION_SIZE` (16): RAM word width; must be 16.
- `ADDR_WIDTH`, default `Isa::MEMORY_ADDRESS_WIDTH` (8): RAM address width.
- `DEPTH`, default `Isa::MEMORY_DEPTH` (256): maximum loadable word count.

Ports:
- `i_clock` in 1: single clock; all logic is on its rising edge.
- `i_reset` in 1: reset, asynchronous, active-low.
- `i_start` in 1: begin a load; sampled only in IDLE, DONE and ERROR.
- `i_data` in 8: stream byte.
- `i_valid` in 1: `i_data` is valid.
- `o_ready` out 1: loader accepts a byte this cycle.
- `o_ram_write_enable` out 1: RAM write strobe, one cycle per word.
- `o_ram_address` out `ADDR_WIDTH`: RAM write address.
- `o_ram_write_data` out `WORD_WIDTH`: RAM write data.
- `o_cpu_reset` out 1: active-low reset driven to the processor's `i_reset`.
- `o_done` out 1: load completed with a good checksum.
- `o_error` out 1: load aborted, either on length overflow or checksum mismatch.

## Operation
- **Handshake:** a byte transfers on a rising edge with `i_valid && o_ready`. There is no other acceptance path.
- **Stream format:** `LEN_HI`, `LEN_LO` (N, 16-bit, big-endian), then N words sent high byte first, then one checksum byte.
- **Checksum:** the XOR of all 2N data bytes. Length bytes are excluded.
- **States:**
  - IDLE: `o_ready`=0. On `i_start`, clear the address counter, word counter and checksum accumulator, then go to LEN_HI.
  - LEN_HI: `o_ready`=1. On accept, latch `N[15:8]`, then go to LEN_LO.
  - LEN_LO: `o_ready`=1. On accept:
    - N > `DEPTH`: go to ERROR.
    - N = 0: go to CHECK.
    - otherwise: go to DATA_HI.
  - DATA_HI: `o_ready`=1. On accept, latch the high byte and XOR it into the checksum, then go to DATA_LO.
  - DATA_LO: `o_ready`=1. On accept, latch the low byte and XOR it in, then go to WRITE.
  - WRITE: `o_ready`=0 and `o_ram_write_enable`=1 for exactly this cycle. The address and data hold the assembled word. Then increment the address and word counters. If the word counter equals N, go to CHECK; otherwise go to DATA_HI.
  - CHECK: `o_ready`=1. On accept, go to DONE if the byte equals the accumulator, otherwise to ERROR.
  - DONE: `o_done`=1 and `o_cpu_reset`=1.
  - ERROR: `o_error`=1 and `o_cpu_reset`=0.
- **Restart:** `i_start` in DONE or ERROR restarts the load, exactly as from IDLE. `o_cpu_reset` drops to 0 on that same edge. `i_start` is ignored in all other states.
- **Counter widths:** the word counter is `ADDR_WIDTH`+1 bits, so it holds 0..256. The address is `ADDR_WIDTH` bits and never wraps, because N ≤ `DEPTH` is enforced before any write.
- **RAM outputs when idle:** `o_ram_address` and `o_ram_write_data` are 0 whenever `o_ram_write_enable`=0.

## Timing
- **Reset:** all outputs are 0, including `o_cpu_reset`=0, so the processor is held in reset. State goes to IDLE. Reset takes effect immediately and asynchronously.
- **Reset mid-load:** any in-progress write is dropped (`o_ram_write_enable` falls at once). Words already written remain in RAM.
- **Word latency:** the low-byte accept edge is followed by WRITE for one cycle. At most one word is written every 3 cycles.
- **Completion:** `o_done` and `o_cpu_reset` rise on the edge after the checksum byte is accepted. `o_error` rises on the edge after the failing byte (`LEN_LO` or checksum).
- **Outputs are registered:**
  - `o_ready` and `o_ram_write_enable` are decoded from the registered state only.
  - Nothing combinational from `i_valid` or `i_data` reaches any output.
- **Stalls:** an idle `i_valid` stalls the loader indefinitely. There is no timeout.

## Structure
- **`Isa` package:** `WORD_WIDTH`, `ADDR_WIDTH` and `DEPTH` come from the existing constants.
- **New package `loader_pkg`:**
  - the state enum `loader_state_t` (IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR);
  - the constant `LOADER_BYTES_PER_WORD` = 2.
  - The testbench probes state through this package.
- **Sub-modules:** none. A single FSM with inline counters and the checksum register is sufficient.
- **Top-level wiring:**
  - The loader's RAM outputs drive the RAM port's write signals while `o_cpu_reset`=0.
  - The processor owns the port once released.

## Test plan
- **Nominal load:** stream 00 03, 23 01, 45 00, 00 00, checksum 67 → mem[0]=2301, mem[1]=4500, mem[2]=0000. Exactly 3 write strobes occur, at addresses 0, 1, 2. `o_done`=1 and `o_cpu_reset`=1 on the edge after the checksum accept.
- **Bad checksum:** same stream with checksum 66 → `o_error`=1, `o_cpu_reset` stays 0, `o_done`=0. A following `i_start` plus the good stream → DONE.
- **Length overflow:** N=01 01 (257) → ERROR on the edge after `LEN_LO`, with no write strobe. N=01 00 (256) is accepted, and its last write targets address 255.
- **Empty program:** 00 00 then checksum 00 → DONE with no write strobe. Checksum 01 → ERROR.
- **Backpressure and gaps:** 256 words with random data and `i_valid` randomly deasserted → every mem[k] matches the sent word. No byte is accepted while `o_ready`=0. Every strobe's address and data pair is correct.
- **Reset mid-load:** assert `i_reset`=0 during DATA_LO of word 5 → all outputs go to 0 immediately and the state is IDLE. Restarting with a new 2-word stream → DONE with mem[0..1] updated.
